// File: rtl/intpol2_mc_controlpath.sv
// Control path for the multichannel, variable-ratio quadratic interpolator:
// sequences window priming, per-channel loads, output phases, FIFO stalls and bypass.
module intpol2_mc_controlpath #(
    parameter int CONFIG_WIDTH = 32,
    parameter int CH_NUM       = 2,
    parameter int MAX_LOG2_R   = 4,
    parameter int CHW          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int LRW          = $clog2(MAX_LOG2_R + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bypass,
    input  logic [LRW-1:0]          log2_r,
    input  logic [CONFIG_WIDTH-1:0] ilen,
    input  logic                    empty_i,
    input  logic                    afull_i,
    output logic                    rd_en,
    output logic                    ld_win,
    output logic [CHW-1:0]          ch_sel,
    output logic [MAX_LOG2_R-1:0]   phase,
    output logic                    wr_en,
    output logic                    fifo_bypass,
    output logic                    clear,
    output logic                    busy,
    output logic                    stop_empty,
    output logic                    stop_afull,
    output logic                    done
);

    localparam int CNTW = CONFIG_WIDTH + 3;
    localparam int PRW  = $clog2(2 * CH_NUM + 1);
    localparam int PSW  = MAX_LOG2_R + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, PRIME, READ, WRITE, BYPASS, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CONFIG_WIDTH-1:0] ilen_q;
    logic                    bypass_q;
    logic [LRW-1:0]          log2_r_q;
    logic [LRW-1:0]          log2_r_clamped;
    logic [CNTW-1:0]         step_cnt;
    logic [CNTW-1:0]         xfer_cnt;
    logic [CNTW-1:0]         step_target;
    logic [CNTW-1:0]         xfer_total;
    logic [PRW-1:0]          prime_cnt;
    logic [PSW-1:0]          phase_span;
    logic [MAX_LOG2_R-1:0]   phase_last;
    logic                    rd_go;
    logic                    wr_go;
    logic                    byp_go;
    logic                    phase_wrap;
    logic                    last_ch;
    logic                    prime_last;
    logic                    step_last;
    logic                    xfer_last;

    assign log2_r_clamped = (log2_r > LRW'(MAX_LOG2_R)) ? LRW'(MAX_LOG2_R) : log2_r;

    // Subtracting from the truncated span keeps the full-ratio case correct (0 - 1 = all ones).
    assign phase_span  = PSW'(1) << log2_r_q;
    assign phase_last  = phase_span[MAX_LOG2_R-1:0] - MAX_LOG2_R'(1);
    assign phase_wrap  = (phase == phase_last);

    assign step_target = CNTW'(ilen_q) - CNTW'(2);
    assign xfer_total  = CNTW'(ilen_q) * CNTW'(CH_NUM);
    assign step_last   = ((step_cnt + CNTW'(1)) == step_target);
    assign xfer_last   = ((xfer_cnt + CNTW'(1)) == xfer_total);
    assign last_ch     = (ch_sel == CHW'(CH_NUM - 1));
    assign prime_last  = (prime_cnt == PRW'(2 * CH_NUM - 1));

    assign rd_go  = ((state == PRIME) || (state == READ)) && !empty_i;
    assign wr_go  = (state == WRITE) && !afull_i;
    assign byp_go = (state == BYPASS) && (xfer_total != '0) && !empty_i && !afull_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = CLEAR;
            CLEAR: begin
                if (bypass_q)                        state_nxt = BYPASS;
                else if (ilen_q < CONFIG_WIDTH'(3))  state_nxt = DONE;
                else                                 state_nxt = PRIME;
            end
            PRIME:  if (rd_go && prime_last) state_nxt = READ;
            READ:   if (rd_go) state_nxt = WRITE;
            WRITE: begin
                if (wr_go && phase_wrap) begin
                    if (last_ch && step_last) state_nxt = DONE;
                    else                      state_nxt = READ;
                end
            end
            BYPASS: if ((xfer_total == '0) || (byp_go && xfer_last)) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job configuration, channel/phase pointers and progress counters; all hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ilen_q    <= '0;
            bypass_q  <= 1'b0;
            log2_r_q  <= '0;
            ch_sel    <= '0;
            phase     <= '0;
            step_cnt  <= '0;
            xfer_cnt  <= '0;
            prime_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ilen_q   <= ilen;
                        bypass_q <= bypass;
                        log2_r_q <= log2_r_clamped;
                    end
                end
                CLEAR: begin
                    ch_sel    <= '0;
                    phase     <= '0;
                    step_cnt  <= '0;
                    xfer_cnt  <= '0;
                    prime_cnt <= '0;
                end
                PRIME: begin
                    if (rd_go) begin
                        prime_cnt <= prime_cnt + PRW'(1);
                        ch_sel    <= last_ch ? '0 : ch_sel + CHW'(1);
                    end
                end
                READ: begin
                    if (rd_go) phase <= '0;
                end
                WRITE: begin
                    if (wr_go) begin
                        if (phase_wrap) begin
                            phase <= '0;
                            if (last_ch) begin
                                ch_sel   <= '0;
                                step_cnt <= step_cnt + CNTW'(1);
                            end else begin
                                ch_sel <= ch_sel + CHW'(1);
                            end
                        end else begin
                            phase <= phase + MAX_LOG2_R'(1);
                        end
                    end
                end
                BYPASS: begin
                    if (byp_go) xfer_cnt <= xfer_cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_en       = 1'b0;
        ld_win      = 1'b0;
        wr_en       = 1'b0;
        fifo_bypass = 1'b0;
        clear       = 1'b0;
        busy        = (state != IDLE);
        stop_empty  = 1'b0;
        stop_afull  = 1'b0;
        done        = 1'b0;
        case (state)
            CLEAR: clear = 1'b1;
            PRIME, READ: begin
                rd_en      = !empty_i;
                ld_win     = !empty_i;
                stop_empty = empty_i;
            end
            WRITE: begin
                wr_en      = !afull_i;
                stop_afull = afull_i;
            end
            BYPASS: begin
                fifo_bypass = 1'b1;
                rd_en       = byp_go;
                wr_en       = byp_go;
                stop_empty  = empty_i;
                stop_afull  = afull_i;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intpol2_mc_controlpath.sv
// Bench for intpol2_mc_controlpath: directed jobs, with expected read/write
// sequences queued at job start and retired as the DUT strobes its FIFOs.
module tb_intpol2_mc_controlpath;

    localparam int CH   = 2;
    localparam int MAXR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bypass;
    logic [2:0]  log2_r;
    logic [31:0] ilen;
    logic        empty_i;
    logic        afull_i;
    logic        rd_en;
    logic        ld_win;
    logic [0:0]  ch_sel;
    logic [3:0]  phase;
    logic        wr_en;
    logic        fifo_bypass;
    logic        clear;
    logic        busy;
    logic        stop_empty;
    logic        stop_afull;
    logic        done;

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rel_now;
    int exp_v;
    int rd_cnt, wr_cnt, ld_cnt, byp_cnt, fb_cnt, clr_cnt, se_cnt, sa_cnt, done_cnt;
    int done_rel, clear_rel, first_rd_rel, max_phase;
    bit job_done;
    int rd_q[$];
    int wr_q[$];
    int byp_q[$];

    intpol2_mc_controlpath #(
        .CONFIG_WIDTH(32),
        .CH_NUM(CH),
        .MAX_LOG2_R(MAXR),
        .CHW(1),
        .LRW(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bypass(bypass),
        .log2_r(log2_r),
        .ilen(ilen),
        .empty_i(empty_i),
        .afull_i(afull_i),
        .rd_en(rd_en),
        .ld_win(ld_win),
        .ch_sel(ch_sel),
        .phase(phase),
        .wr_en(wr_en),
        .fifo_bypass(fifo_bypass),
        .clear(clear),
        .busy(busy),
        .stop_empty(stop_empty),
        .stop_afull(stop_afull),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Scoreboard retirement happens on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            rel_now = cyc - start_cyc + 1;
            if (clear) begin
                clr_cnt++;
                if (clear_rel < 0) clear_rel = rel_now;
            end
            if (done) begin
                done_cnt++;
                if (!job_done) done_rel = rel_now;
                job_done = 1'b1;
            end
            if (stop_empty) se_cnt++;
            if (stop_afull) sa_cnt++;
            if (ld_win) ld_cnt++;
            if (fifo_bypass) begin
                fb_cnt++;
                checkOutput("byp_rd", rd_en, !empty_i && !afull_i);
                checkOutput("byp_wr", wr_en, !empty_i && !afull_i);
                checkOutput("byp_stop_empty", stop_empty, empty_i);
                checkOutput("byp_stop_afull", stop_afull, afull_i);
                if (rd_en) begin
                    byp_cnt++;
                    if (byp_q.size() == 0) checkOutput("byp_extra", rd_en, 1'b0);
                    else void'(byp_q.pop_front());
                end
            end else begin
                if (rd_en) begin
                    rd_cnt++;
                    if (first_rd_rel < 0) first_rd_rel = rel_now;
                    if (rd_q.size() == 0) begin
                        checkOutput("rd_extra", rd_en, 1'b0);
                    end else begin
                        exp_v = rd_q.pop_front();
                        checkOutput("rd_ch", ch_sel, exp_v);
                    end
                end
                if (wr_en) begin
                    wr_cnt++;
                    if (int'(phase) > max_phase) max_phase = int'(phase);
                    if (wr_q.size() == 0) begin
                        checkOutput("wr_extra", wr_en, 1'b0);
                    end else begin
                        exp_v = wr_q.pop_front();
                        checkOutput("wr_ch", ch_sel, exp_v / 256);
                        checkOutput("wr_phase", phase, exp_v % 256);
                    end
                end
            end
        end
    end

    task automatic startJob(input bit byp, input int l2r, input int len);
        int r;
        r = (l2r > MAXR) ? MAXR : l2r;
        rd_q.delete();
        wr_q.delete();
        byp_q.delete();
        if (byp) begin
            for (int i = 0; i < len * CH; i++) byp_q.push_back(i);
        end else if (len >= 3) begin
            for (int i = 0; i < len * CH; i++) rd_q.push_back(i % CH);
            for (int s = 0; s < len - 2; s++)
                for (int c = 0; c < CH; c++)
                    for (int p = 0; p < (1 << r); p++) wr_q.push_back(c * 256 + p);
        end
        rd_cnt = 0; wr_cnt = 0; ld_cnt = 0; byp_cnt = 0; fb_cnt = 0; clr_cnt = 0;
        se_cnt = 0; sa_cnt = 0; done_cnt = 0; max_phase = 0;
        done_rel = -1; clear_rel = -1; first_rd_rel = -1;
        job_done = 1'b0;
        bypass = byp;
        log2_r = 3'(l2r);
        ilen   = 32'(len);
        start  = 1'b1;
        start_cyc = cyc + 1;
    endtask

    // Caller is #1 after a rising edge in an idle cycle; returns #1 after the edge following done.
    task automatic applyStimulus(input bit byp, input int l2r, input int len,
                                 input int e_from, input int e_len,
                                 input int a_from, input int a_len,
                                 input bit alt_empty, input int start_again);
        int rel;
        startJob(byp, l2r, len);
        for (int n = 0; n < 400 && !job_done; n++) begin
            @(posedge clk);
            #1;
            rel = cyc - start_cyc + 1;
            start   = (rel == start_again);
            empty_i = alt_empty ? rel[0] : ((rel >= e_from) && (rel < e_from + e_len));
            afull_i = (rel >= a_from) && (rel < a_from + a_len);
        end
        checkOutput("done_seen", job_done, 1'b1);
        start   = 1'b0;
        empty_i = 1'b0;
        afull_i = 1'b0;
        checkOutput("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bypass = 1'b0; log2_r = 3'd0; ilen = 32'd0;
        empty_i = 1'b1; afull_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {rd_en, ld_win, ch_sel, phase, wr_en, fifo_bypass, clear, busy, stop_empty, stop_afull, done}, 64'd0);
        rst = 1'b0; empty_i = 1'b0; afull_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);

        // Baseline job: ratio 4, four samples per channel, no stalls.
        applyStimulus(1'b0, 2, 4, -1, 0, -1, 0, 1'b0, -1);
        checkOutput("j1_clear_cycle", clear_rel, 1);
        checkOutput("j1_clear_len", clr_cnt, 1);
        checkOutput("j1_first_read", first_rd_rel, 2);
        checkOutput("j1_reads", rd_cnt, 8);
        checkOutput("j1_loads", ld_cnt, 8);
        checkOutput("j1_writes", wr_cnt, 16);
        checkOutput("j1_max_phase", max_phase, 3);
        checkOutput("j1_done_cycle", done_rel, 26);
        checkOutput("j1_done_pulses", done_cnt, 1);
        checkOutput("j1_rd_left", rd_q.size(), 0);
        checkOutput("j1_wr_left", wr_q.size(), 0);

        // Input FIFO empty for three cycles during the first READ.
        applyStimulus(1'b0, 2, 4, 6, 3, -1, 0, 1'b0, -1);
        checkOutput("j2_clear_cycle", clear_rel, 1);
        checkOutput("j2_stop_empty", se_cnt, 3);
        checkOutput("j2_reads", rd_cnt, 8);
        checkOutput("j2_writes", wr_cnt, 16);
        checkOutput("j2_done_cycle", done_rel, 29);

        // Output FIFO almost full for five cycles starting at phase 2.
        applyStimulus(1'b0, 2, 4, -1, 0, 9, 5, 1'b0, -1);
        checkOutput("j3_stop_afull", sa_cnt, 5);
        checkOutput("j3_stop_empty", se_cnt, 0);
        checkOutput("j3_writes", wr_cnt, 16);
        checkOutput("j3_wr_left", wr_q.size(), 0);
        checkOutput("j3_done_cycle", done_rel, 31);

        // Bypass with alternating empty input.
        applyStimulus(1'b1, 2, 5, -1, 0, -1, 0, 1'b1, -1);
        checkOutput("j4_transfers", byp_cnt, 10);
        checkOutput("j4_bypass_cycles", fb_cnt, 19);
        checkOutput("j4_loads", ld_cnt, 0);
        checkOutput("j4_stop_empty", se_cnt, 9);
        checkOutput("j4_byp_left", byp_q.size(), 0);
        checkOutput("j4_done_cycle", done_rel, 21);

        // Too short to interpolate; a start pulse during DONE must be ignored.
        applyStimulus(1'b0, 2, 2, -1, 0, -1, 0, 1'b0, 2);
        checkOutput("j5_done_cycle", done_rel, 2);
        checkOutput("j5_reads", rd_cnt, 0);
        checkOutput("j5_writes", wr_cnt, 0);

        // Oversized ratio clamps to 16 phases.
        applyStimulus(1'b0, 7, 3, -1, 0, -1, 0, 1'b0, -1);
        checkOutput("j6_reads", rd_cnt, 6);
        checkOutput("j6_writes", wr_cnt, 32);
        checkOutput("j6_max_phase", max_phase, 15);
        checkOutput("j6_done_cycle", done_rel, 40);

        // Abort mid-WRITE, then run a full job from the first cycle after release.
        startJob(1'b0, 2, 4);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("abort_busy_before", busy, 1'b1);
        checkOutput("abort_in_write", wr_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs",
                    {rd_en, ld_win, ch_sel, phase, wr_en, fifo_bypass, clear, busy, stop_empty, stop_afull, done}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_cnt, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 2, 4, -1, 0, -1, 0, 1'b0, -1);
        checkOutput("j7_clear_cycle", clear_rel, 1);
        checkOutput("j7_reads", rd_cnt, 8);
        checkOutput("j7_writes", wr_cnt, 16);
        checkOutput("j7_done_cycle", done_rel, 26);
        checkOutput("j7_done_pulses", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
